// File: rtl/counter_bank_with_strobe_pkg.sv
// counter_bank_with_strobe_pkg: shared mode encoding and channel-index width helper
package counter_bank_with_strobe_pkg;
  typedef enum logic {MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1} mode_e;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/counter_bank_with_strobe_channel.sv
// counter_bank_with_strobe_channel: one event counter with programmable period and pipelined completion
module counter_bank_with_strobe_channel
  import counter_bank_with_strobe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             cfg_we_i,
  input  logic [WIDTH-1:0] cfg_period_i,
  input  logic             cfg_oneshot_i,
  output logic             strobe_o,
  output logic             ready_o,
  output logic             active_o
);
  logic [WIDTH-1:0] count_q, count_d, period_q, period_d;
  mode_e mode_q, mode_d;
  logic active_q, active_d, strobe_q, strobe_d;
  logic [LATENCY:0] v, h;
  logic fire, hit;
  assign v[0] = enable_i && ready_o && active_q && period_q != '0 && !cfg_we_i;
  // State is frozen while an op is in flight, so the compare can be taken at accept time
  assign h[0] = count_q == period_q;
  assign fire = v[LATENCY];
  assign hit  = h[LATENCY];
  generate
    if (LATENCY > 0) begin : g_pipe
      logic [LATENCY-1:0] v_q, h_q;
      always_ff @(posedge clk) begin
        v_q <= (rst || cfg_we_i) ? '0 : v[LATENCY-1:0];
        h_q <= h[LATENCY-1:0];
      end
      assign v[LATENCY:1] = v_q;
      assign h[LATENCY:1] = h_q;
      assign ready_o = ~|v_q;
    end else begin : g_nopipe
      assign ready_o = 1'b1;
    end
  endgenerate
  assign period_d = cfg_we_i ? cfg_period_i : period_q;
  assign mode_d   = cfg_we_i ? mode_e'(cfg_oneshot_i) : mode_q;
  assign count_d  = (cfg_we_i || (fire && hit)) ? WIDTH'(1) : fire ? count_q + 1'b1 : count_q;
  assign active_d = cfg_we_i || (active_q && !(fire && hit && mode_q == MODE_ONESHOT));
  assign strobe_d = fire && hit && !cfg_we_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= WIDTH'(1);
      period_q <= '1;
      mode_q   <= MODE_PERIODIC;
      active_q <= 1'b1;
      strobe_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      strobe_q <= strobe_d;
    end
  end
  assign strobe_o = strobe_q;
  assign active_o = active_q;
`ifdef FORMAL
  a_strobe_pulse: assert property (@(posedge clk) disable iff (rst) strobe_q && period_q > 1 |=> !strobe_q);
  a_oneshot_disarm: assert property (@(posedge clk) disable iff (rst) strobe_q && mode_q == MODE_ONESHOT |-> !active_q);
`endif
endmodule

// File: rtl/counter_bank_with_strobe.sv
// counter_bank_with_strobe: bank of independent strobe counters with addressed configuration
module counter_bank_with_strobe
  import counter_bank_with_strobe_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int LATENCY  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           enable_i,
  input  logic                          cfg_we_i,
  input  logic [ch_w(CHANNELS)-1:0]     cfg_ch_i,
  input  logic [WIDTH-1:0]              cfg_period_i,
  input  logic                          cfg_oneshot_i,
  output logic [CHANNELS-1:0]           strobe_o,
  output logic [CHANNELS-1:0]           ready_o,
  output logic [CHANNELS-1:0]           active_o
);
  localparam int CW = ch_w(CHANNELS);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    counter_bank_with_strobe_channel #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable_i[c]),
      .cfg_we_i     (cfg_we_i && cfg_ch_i == CW'(c)),
      .cfg_period_i (cfg_period_i),
      .cfg_oneshot_i(cfg_oneshot_i),
      .strobe_o     (strobe_o[c]),
      .ready_o      (ready_o[c]),
      .active_o     (active_o[c])
    );
  end
endmodule

// File: tb/tb_counter_bank_with_strobe.sv
// tb_counter_bank_with_strobe: directed vectors against LATENCY 0, 2 and 3 instances sharing one stimulus
module tb_counter_bank_with_strobe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] enable = '0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic cfg_oneshot = 1'b0;
  logic [3:0] s0, r0, a0, s2, r2, a2, s3, r3, a3;
  int n_vec = 0;
  int n_err = 0;
  int hits;

  always #5 clk = ~clk;

  counter_bank_with_strobe #(.WIDTH(8), .CHANNELS(4), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .enable_i(enable), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_period_i(cfg_period), .cfg_oneshot_i(cfg_oneshot), .strobe_o(s0), .ready_o(r0), .active_o(a0));
  counter_bank_with_strobe #(.WIDTH(8), .CHANNELS(4), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .enable_i(enable), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_period_i(cfg_period), .cfg_oneshot_i(cfg_oneshot), .strobe_o(s2), .ready_o(r2), .active_o(a2));
  counter_bank_with_strobe #(.WIDTH(8), .CHANNELS(4), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .enable_i(enable), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_period_i(cfg_period), .cfg_oneshot_i(cfg_oneshot), .strobe_o(s3), .ready_o(r3), .active_o(a3));

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int period, input bit oneshot);
    cfg_we = 1'b1;
    cfg_ch = 2'(ch);
    cfg_period = 8'(period);
    cfg_oneshot = oneshot;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_strobe", int'(s0), 0);
    chk("rst_ready_l0", int'(r0), 15);
    chk("rst_active", int'(a0), 15);
    chk("rst_ready_l2", int'(r2), 15);
    chk("rst_ready_l3", int'(r3), 15);

    cfg(0, 3, 1'b0);
    enable = 4'b0001;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("p3_strobe_k%0d", k), int'(s0[0]), int'(k % 3 == 0));
    end
    enable = '0;

    cfg(1, 2, 1'b1);
    enable = 4'b0010;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("os_strobe_k%0d", k), int'(s0[1]), int'(k == 2));
      chk($sformatf("os_active_k%0d", k), int'(a0[1]), int'(k < 2));
    end
    enable = '0;
    cfg(1, 2, 1'b1);
    chk("os_rearm", int'(a0[1]), 1);

    cfg(0, 2, 1'b0);
    chk("l2_ready_idle", int'(r2[0]), 1);
    enable = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("l2_ready_k%0d", k), int'(r2[0]), int'(k % 3 == 0));
      chk($sformatf("l2_strobe_k%0d", k), int'(s2[0]), int'(k % 6 == 0));
    end
    enable = '0;

    cfg(2, 1, 1'b0);
    cfg(0, 3, 1'b0);
    enable = 4'b0001;
    tick();
    tick();
    chk("coll_pre_strobe", int'(s0[0]), 0);
    cfg_we = 1'b1;
    cfg_ch = 2'd0;
    cfg_period = 8'd3;
    cfg_oneshot = 1'b0;
    enable = 4'b0101;
    tick();
    cfg_we = 1'b0;
    chk("coll_ch0_dropped", int'(s0[0]), 0);
    chk("coll_ch2_counts", int'(s0[2]), 1);
    enable = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("coll_after_k%0d", k), int'(s0[0]), int'(k == 3));
    end
    enable = '0;

    cfg(3, 0, 1'b0);
    enable = 4'b1000;
    hits = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      hits += int'(s0[3]);
    end
    chk("p0_strobes", hits, 0);
    chk("p0_ready", int'(r0[3]), 1);
    enable = '0;
    cfg(3, 1, 1'b0);
    enable = 4'b1000;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("p1_strobe_k%0d", k), int'(s0[3]), 1);
    end
    enable = '0;
    tick();
    chk("p1_idle", int'(s0[3]), 0);

    cfg(0, 1, 1'b0);
    enable = 4'b0001;
    tick();
    enable = '0;
    chk("l3_busy", int'(r3[0]), 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("l3_rst_strobe", int'(s3), 0);
    chk("l3_rst_ready", int'(r3), 15);
    chk("l3_rst_active", int'(a3), 15);
    tick();
    chk("l3_no_late_strobe", int'(s3), 0);
    tick();
    chk("l3_quiet", int'(s3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
